// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit CPU front end: opcodes, PC command
// encodings, default widths and the fetch sequencer state encoding.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF  = 14;
  localparam int unsigned INSTR_W_DEF = 19;
  localparam int unsigned OPC_W       = 5;

  // Opcodes resolved inside the sequencer; everything else goes to execute.
  localparam logic [OPC_W-1:0] OP_NOP  = 5'h00;
  localparam logic [OPC_W-1:0] OP_JMP  = 5'h10;
  localparam logic [OPC_W-1:0] OP_BEQ  = 5'h11;
  localparam logic [OPC_W-1:0] OP_BNE  = 5'h12;
  localparam logic [OPC_W-1:0] OP_CALL = 5'h13;
  localparam logic [OPC_W-1:0] OP_RET  = 5'h14;
  localparam logic [OPC_W-1:0] OP_HLT  = 5'h1F;

  // PC command as {loadPC, incPC}.
  localparam logic [1:0] PC_CLR  = 2'b00;
  localparam logic [1:0] PC_LOAD = 2'b10;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_HOLD = 2'b11;

  typedef enum logic [2:0] {
    ST_CLR,
    ST_SETTLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_ADV_INC,
    ST_ADV_LOAD,
    ST_HALT
  } fetch_state_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack: DEPTH entries of DATA_W bits, push/pop with
// full/empty status. Only the stack pointer is reset; entries keep stale data.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push, pop  operations (ignored when full / empty respectively)
//   wdata      value pushed
//   top_c      entry at top of stack (decoded from sp)
//   full_c     all entries in use
//   empty_c    no entries in use
module ret_stack #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] top_c,
  output logic              full_c,
  output logic              empty_c
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SP_W  = $clog2(DEPTH) + 1;

  logic [SP_W-1:0]   sp;
  logic [DATA_W-1:0] mem [DEPTH];

  assign full_c  = (sp == SP_W'(DEPTH));
  assign empty_c = (sp == '0);
  assign top_c   = mem[IDX_W'(sp - SP_W'(1))];

  // Stack pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full_c) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty_c) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (push && !full_c) begin
      mem[IDX_W'(sp)] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter control FSM: fetch -> decode -> execute -> PC advance.
// Resolves JMP/BEQ/BNE/CALL/RET/HLT locally, hands other opcodes to the
// execute datapath, and waits SETTLE_CYCLES after every PC command.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pc_value            current PC (lags its command by two edges)
//   loadPC, incPC       PC command: 00 clear, 10 load, 01 inc, 11 hold
//   pc_address          load target for the PC
//   mem_req, mem_addr   instruction read request and address
//   mem_ack, mem_rdata  read completion and instruction word
//   ir                  latched instruction
//   exec_start          one-cycle start pulse to the execute datapath
//   exec_done           execute complete
//   zero_flag           ALU zero flag, sampled in DECODE
//   halted              high in HALT
//   stack_err           sticky return-stack overflow/underflow
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned INSTR_W       = INSTR_W_DEF,
  parameter int unsigned STACK_DEPTH   = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic               loadPC,
  output logic               incPC,
  output logic [ADDR_W-1:0]  pc_address,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               exec_start,
  input  logic               exec_done,
  input  logic               zero_flag,
  output logic               halted,
  output logic               stack_err
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  fetch_state_e     state, state_d;
  logic [CNT_W-1:0] settle_cnt;
  logic [ADDR_W-1:0] target_d;
  logic [1:0]       pc_cmd_d;
  logic             push, pop, err_d;
  logic [ADDR_W-1:0] stk_top_c;
  logic             stk_full_c, stk_empty_c;
  logic [OPC_W-1:0] opcode;
  logic [ADDR_W-1:0] ir_target;

  assign opcode    = ir[INSTR_W-1 -: OPC_W];
  assign ir_target = ir[ADDR_W-1:0];

  ret_stack #(
    .DATA_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wdata   (pc_value + ADDR_W'(1)),
    .top_c   (stk_top_c),
    .full_c  (stk_full_c),
    .empty_c (stk_empty_c)
  );

  // Next state, branch target and stack control
  always_comb begin
    state_d  = state;
    target_d = ir_target;
    push     = 1'b0;
    pop      = 1'b0;
    err_d    = 1'b0;
    case (state)
      ST_CLR:    state_d = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_FETCH;
      ST_FETCH:  if (mem_ack) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_NOP: state_d = ST_ADV_INC;
          OP_JMP: state_d = ST_ADV_LOAD;
          OP_BEQ: state_d = zero_flag ? ST_ADV_LOAD : ST_ADV_INC;
          OP_BNE: state_d = zero_flag ? ST_ADV_INC : ST_ADV_LOAD;
          OP_CALL: begin
            if (stk_full_c) begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              push    = 1'b1;
              state_d = ST_ADV_LOAD;
            end
          end
          OP_RET: begin
            if (stk_empty_c) begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              pop      = 1'b1;
              target_d = stk_top_c;
              state_d  = ST_ADV_LOAD;
            end
          end
          OP_HLT:  state_d = ST_HALT;
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC:     if (exec_done) state_d = ST_ADV_INC;
      ST_ADV_INC:  state_d = ST_SETTLE;
      ST_ADV_LOAD: state_d = ST_SETTLE;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_CLR;
    endcase

    // Outputs are registered from the state being entered.
    pc_cmd_d = PC_HOLD;
    case (state_d)
      ST_CLR:      pc_cmd_d = PC_CLR;
      ST_ADV_INC:  pc_cmd_d = PC_INC;
      ST_ADV_LOAD: pc_cmd_d = PC_LOAD;
      default:     pc_cmd_d = PC_HOLD;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_CLR;
      settle_cnt        <= '0;
      {loadPC, incPC}   <= PC_CLR;
      pc_address        <= '0;
      mem_req           <= 1'b0;
      mem_addr          <= '0;
      ir                <= '0;
      exec_start        <= 1'b0;
      halted            <= 1'b0;
      stack_err         <= 1'b0;
    end else begin
      state           <= state_d;
      settle_cnt      <= (state == ST_SETTLE) ? settle_cnt + CNT_W'(1) : '0;
      {loadPC, incPC} <= pc_cmd_d;
      if (state_d == ST_ADV_LOAD) pc_address <= target_d;
      mem_req <= (state_d == ST_FETCH);
      // PC is settled and held for the whole fetch; capture it on entry.
      if (state_d == ST_FETCH && state != ST_FETCH) mem_addr <= pc_value;
      if (state == ST_FETCH && mem_ack) ir <= mem_rdata;
      exec_start <= (state_d == ST_EXEC) && (state != ST_EXEC);
      halted     <= (state_d == ST_HALT);
      stack_err  <= stack_err | err_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with PC, memory and execute models and
// scoreboards of expected fetch addresses and PC commands.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] pc_value;
  logic        loadPC, incPC;
  logic [13:0] pc_address;
  logic        mem_req;
  logic [13:0] mem_addr;
  logic        mem_ack;
  logic [18:0] mem_rdata;
  logic [18:0] ir;
  logic        exec_start, exec_done;
  logic        zero_flag = 1'b0;
  logic        halted, stack_err;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .pc_value   (pc_value),
    .loadPC     (loadPC),
    .incPC      (incPC),
    .pc_address (pc_address),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ir         (ir),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .zero_flag  (zero_flag),
    .halted     (halted),
    .stack_err  (stack_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // PC model: command applied two edges after it is driven.
  logic [1:0]  cmd_q = 2'b00;
  logic [13:0] addr_q = '0;
  logic [13:0] pc = '0;
  always @(posedge clk) begin
    cmd_q  <= {loadPC, incPC};
    addr_q <= pc_address;
    case (cmd_q)
      PC_CLR:  pc <= '0;
      PC_LOAD: pc <= addr_q;
      PC_INC:  pc <= pc + 14'd1;
      default: pc <= pc;
    endcase
  end
  assign pc_value = pc;

  // Instruction memory with programmable ack latency.
  logic [18:0] imem [16384];
  int   ack_delay = 0;
  int   wait_cnt = 0;
  logic late_ack = 1'b0;
  assign mem_ack   = (mem_req && wait_cnt == ack_delay) || late_ack;
  assign mem_rdata = imem[mem_addr];
  always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

  // Execute model: done exec_delay cycles after start (0 = same cycle).
  int   exec_delay = 0;
  int   ecnt = 0;
  logic ebusy = 1'b0;
  assign exec_done = (exec_delay == 0) ? exec_start : (ebusy && ecnt == exec_delay);
  always @(posedge clk) begin
    if (exec_start && exec_delay != 0) begin
      ebusy <= 1'b1;
      ecnt  <= 1;
    end else if (ebusy) begin
      if (exec_done) ebusy <= 1'b0;
      else ecnt <= ecnt + 1;
    end
  end

  typedef struct { logic [13:0] addr; int gap; } fetch_t;
  typedef struct { logic [1:0] cmd; logic [13:0] addr; } cmd_t;
  fetch_t fq[$];
  cmd_t   cq[$];

  task automatic push_f(input logic [13:0] a, input int gap);
    fetch_t f;
    f.addr = a;
    f.gap  = gap;
    fq.push_back(f);
  endtask

  task automatic push_c(input logic [1:0] c, input logic [13:0] a);
    cmd_t e;
    e.cmd  = c;
    e.addr = a;
    cq.push_back(e);
  endtask

  function automatic logic [18:0] ins(input logic [4:0] op, input logic [13:0] t);
    return {op, t};
  endfunction

  // Monitor: pops scoreboards on fetch acceptance and PC commands.
  int cyc = 0, last_fetch = 0, last_cmd = -100, req_len = 0;
  int n_exec_start = 0, start_cyc = 0, inc_cyc = 0;
  bit after_ack = 1'b0;
  initial begin : monitor
    fetch_t f;
    cmd_t   c;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        last_fetch = 0; last_cmd = -100; req_len = 0; after_ack = 1'b0;
        n_exec_start = 0; start_cyc = 0; inc_cyc = 0;
      end else begin
        chk("req_exec_excl", 32'(mem_req & exec_start), 32'd0);
        if (after_ack) begin
          chk("req_drop_after_ack", 32'(mem_req), 32'd0);
          after_ack = 1'b0;
        end
        if (mem_req) req_len++; else req_len = 0;
        if (mem_req && mem_ack) begin
          chk("fetch_sb_nonempty", 32'(fq.size() != 0), 32'd1);
          if (fq.size() != 0) begin
            f = fq.pop_front();
            chk("fetch_addr", 32'(mem_addr), 32'(f.addr));
            if (f.gap != 0) chk("fetch_gap", 32'(cyc - last_fetch), 32'(f.gap));
          end
          chk("req_len", 32'(req_len), 32'(ack_delay + 1));
          last_fetch = cyc;
          after_ack  = 1'b1;
        end
        if ({loadPC, incPC} == PC_INC || {loadPC, incPC} == PC_LOAD) begin
          chk("cmd_spacing", 32'(cyc - last_cmd >= 3), 32'd1);
          last_cmd = cyc;
          chk("cmd_sb_nonempty", 32'(cq.size() != 0), 32'd1);
          if (cq.size() != 0) begin
            c = cq.pop_front();
            chk("pc_cmd", 32'({loadPC, incPC}), 32'(c.cmd));
            if (c.cmd == PC_LOAD) chk("load_target", 32'(pc_address), 32'(c.addr));
          end
          if ({loadPC, incPC} == PC_INC) inc_cyc = cyc;
        end
        if (exec_start) begin
          n_exec_start++;
          start_cyc = cyc;
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 16384; i++) imem[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pc_cmd", 32'({loadPC, incPC}), 32'(PC_CLR));
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_exec_start", 32'(exec_start), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stack_err", 32'(stack_err), 32'd0);
    chk("rst_pc_address", 32'(pc_address), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("clr_after_release", 32'({loadPC, incPC}), 32'(PC_CLR));
  endtask

  task automatic finish_test(input string tag, input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_halted"}, 32'(halted), 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_fetch_sb_empty"}, 32'(fq.size()), 32'd0);
    chk({tag, "_cmd_sb_empty"}, 32'(cq.size()), 32'd0);
    chk({tag, "_hold_in_halt"}, 32'({loadPC, incPC}), 32'(PC_HOLD));
    chk({tag, "_no_req_in_halt"}, 32'(mem_req), 32'd0);
    fq.delete();
    cq.delete();
  endtask

  initial begin : stimulus
    int n;

    // Straight-line NOPs, single-cycle memory
    clear_mem();
    imem[4] = ins(OP_HLT, 14'h0);
    push_f(14'h0, 0);
    for (int a = 1; a <= 4; a++) push_f(14'(a), 5);
    repeat (4) push_c(PC_INC, 14'h0);
    do_reset();
    finish_test("straight", 200);
    chk("straight_pc_held", 32'(pc_value), 32'h4);
    chk("straight_no_err", 32'(stack_err), 32'd0);

    // JMP, then wrap 3FFF -> 0000
    clear_mem();
    imem[14'h0]   = ins(OP_JMP, 14'h0ABC);
    imem[14'h0ABC] = ins(OP_JMP, 14'h3FFF);
    push_f(14'h0, 0); push_f(14'h0ABC, 5); push_f(14'h3FFF, 5); push_f(14'h0, 5);
    push_c(PC_LOAD, 14'h0ABC); push_c(PC_LOAD, 14'h3FFF); push_c(PC_INC, 14'h0);
    do_reset();
    n = 0;
    while (!(loadPC && !incPC) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("jmp_load_seen", 32'(loadPC && !incPC), 32'd1);
    imem[14'h0] = ins(OP_HLT, 14'h0);
    finish_test("jmp_wrap", 200);
    chk("jmp_wrap_ir", 32'(ir), 32'(ins(OP_HLT, 14'h0)));

    // BEQ taken / BNE not taken with zero_flag = 1
    clear_mem();
    zero_flag = 1'b1;
    imem[14'h000] = ins(OP_BEQ, 14'h100);
    imem[14'h100] = ins(OP_BNE, 14'h200);
    imem[14'h101] = ins(OP_HLT, 14'h0);
    push_f(14'h0, 0); push_f(14'h100, 5); push_f(14'h101, 5);
    push_c(PC_LOAD, 14'h100); push_c(PC_INC, 14'h0);
    do_reset();
    finish_test("branch_z1", 200);

    // BEQ not taken / BNE taken with zero_flag = 0
    clear_mem();
    zero_flag = 1'b0;
    imem[14'h000] = ins(OP_BEQ, 14'h100);
    imem[14'h001] = ins(OP_BNE, 14'h200);
    imem[14'h200] = ins(OP_HLT, 14'h0);
    push_f(14'h0, 0); push_f(14'h1, 5); push_f(14'h200, 5);
    push_c(PC_INC, 14'h0); push_c(PC_LOAD, 14'h200);
    do_reset();
    finish_test("branch_z0", 200);

    // CALL 0x050 from 0x010, RET back to 0x011
    clear_mem();
    imem[14'h000] = ins(OP_JMP, 14'h010);
    imem[14'h010] = ins(OP_CALL, 14'h050);
    imem[14'h050] = ins(OP_RET, 14'h0);
    imem[14'h011] = ins(OP_HLT, 14'h0);
    push_f(14'h0, 0); push_f(14'h010, 5); push_f(14'h050, 5); push_f(14'h011, 5);
    push_c(PC_LOAD, 14'h010); push_c(PC_LOAD, 14'h050); push_c(PC_LOAD, 14'h011);
    do_reset();
    finish_test("call_ret", 200);
    chk("call_ret_no_err", 32'(stack_err), 32'd0);

    // Five nested CALLs overflow a 4-deep stack
    clear_mem();
    for (int k = 0; k < 5; k++) imem[14'(k * 'h100)] = ins(OP_CALL, 14'((k + 1) * 'h100));
    push_f(14'h0, 0);
    for (int k = 1; k < 5; k++) push_f(14'(k * 'h100), 5);
    for (int k = 1; k < 5; k++) push_c(PC_LOAD, 14'(k * 'h100));
    do_reset();
    finish_test("overflow", 300);
    chk("overflow_stack_err", 32'(stack_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("overflow_pc_held", 32'(pc_value), 32'h400);

    // RET with empty stack
    clear_mem();
    imem[14'h0] = ins(OP_RET, 14'h0);
    push_f(14'h0, 0);
    do_reset();
    finish_test("underflow", 100);
    chk("underflow_stack_err", 32'(stack_err), 32'd1);

    // ALU op with slow memory and slow execute
    clear_mem();
    imem[14'h0] = ins(5'h03, 14'h0);
    imem[14'h1] = ins(OP_HLT, 14'h0);
    ack_delay  = 4;
    exec_delay = 7;
    push_f(14'h0, 0); push_f(14'h1, 0);
    push_c(PC_INC, 14'h0);
    do_reset();
    finish_test("exec_slow", 300);
    chk("exec_slow_starts", 32'(n_exec_start), 32'd1);
    chk("exec_slow_inc_after_done", 32'(inc_cyc - start_cyc), 32'd8);

    // ALU op with exec_done in the same cycle as exec_start
    ack_delay  = 0;
    exec_delay = 0;
    push_f(14'h0, 0); push_f(14'h1, 5 + 1);
    push_c(PC_INC, 14'h0);
    do_reset();
    finish_test("exec_fast", 200);
    chk("exec_fast_starts", 32'(n_exec_start), 32'd1);
    chk("exec_fast_inc_after_done", 32'(inc_cyc - start_cyc), 32'd1);

    // Reset while a fetch is outstanding; late ack afterwards is ignored
    clear_mem();
    imem[14'h1] = ins(OP_HLT, 14'h0);
    ack_delay = 10;
    do_reset();
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_req_seen", 32'(mem_req), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req_async", 32'(mem_req), 32'd0);
    chk("midrst_cmd_async", 32'({loadPC, incPC}), 32'(PC_CLR));
    ack_delay = 0;
    push_f(14'h0, 0); push_f(14'h1, 5);
    push_c(PC_INC, 14'h0);
    do_reset();
    late_ack = 1'b1;
    repeat (2) @(negedge clk);
    late_ack = 1'b0;
    chk("midrst_ir_after_late_ack", 32'(ir), 32'd0);
    finish_test("midrst", 200);
    chk("midrst_ir", 32'(ir), 32'(ins(OP_HLT, 14'h0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
